mul8_seq_ctrl: RTL and testbench

- Sequencing controller computing an unsigned 8x8 -> 16-bit product by time-multiplexing one dadda4 4x4 combinational multiplier over 4 steps.
- One nibble product per step; results are shifted and summed into a 16-bit accumulator.
- Valid/ready handshake on the operand side and on the result side.
- Sits between a small-footprint datapath client and the shared dadda4 instance, trading latency for area.

---
 rtl/mul8_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mul8_seq_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: unsigned 8x8->16 multiply using one 4x4 dadda4 over 4 steps.
// Ports:
//   clk, rst_n (sync, active-low)
//   in_valid/in_ready, a[7:0], b[7:0]   : operand handshake
//   out_valid/out_ready, p[15:0]        : result handshake
//   busy                                : high while stepping through MUL
// Param HOLD_RESULT: 1 keeps p after output handshake, 0 clears it.
// Option macro MUL8_ZERO_BYPASS_EN: a zero operand skips MUL (IDLE->DONE).

module dadda4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [6:0] Z,
  output logic       Cout
);

  logic [7:0] r0, r1, r2, r3;
  logic [7:0] sum;

  always_comb begin
    r0  = {4'b0, A & {4{B[0]}}};
    r1  = {3'b0, A & {4{B[1]}}, 1'b0};
    r2  = {2'b0, A & {4{B[2]}}, 2'b0};
    r3  = {1'b0, A & {4{B[3]}}, 3'b0};
    sum = r0 + r1 + r2 + r3;
  end

  assign Z    = sum[6:0];
  assign Cout = sum[7];

endmodule

module mul8_seq_ctrl #(
  parameter bit HOLD_RESULT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  step;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] acc;
  logic [15:0] p_q;

  logic [3:0]  m_a;
  logic [3:0]  m_b;
  logic [6:0]  m_z;
  logic        m_c;
  logic [7:0]  prod;
  logic [15:0] term;
  logic [15:0] acc_next;
  logic        zero_op;

  // Multiplier inputs idle at 0 outside MUL to avoid needless toggling.
  always_comb begin
    m_a = 4'h0;
    m_b = 4'h0;
    if (state == S_MUL) begin
      unique case (1'b1)
        step == 2'd0: begin
          m_a = a_q[3:0];
          m_b = b_q[3:0];
        end
        step == 2'd1: begin
          m_a = a_q[7:4];
          m_b = b_q[3:0];
        end
        step == 2'd2: begin
          m_a = a_q[3:0];
          m_b = b_q[7:4];
        end
        default: begin
          m_a = a_q[7:4];
          m_b = b_q[7:4];
        end
      endcase
    end
  end

  dadda4 u_dadda4 (
    .A    (m_a),
    .B    (m_b),
    .Z    (m_z),
    .Cout (m_c)
  );

  assign prod = {m_c, m_z};

  always_comb begin
    term = 16'h0;
    unique case (1'b1)
      step == 2'd0: term = {8'h0, prod};
      step == 2'd3: term = {prod, 8'h0};
      default:      term = {4'h0, prod, 4'h0};
    endcase
    acc_next = acc + term;
  end

`ifdef MUL8_ZERO_BYPASS_EN
  assign zero_op = (a == 8'h0) || (b == 8'h0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      step  <= 2'd0;
      a_q   <= 8'h0;
      b_q   <= 8'h0;
      acc   <= 16'h0;
      p_q   <= 16'h0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q  <= a;
            b_q  <= b;
            acc  <= 16'h0;
            step <= 2'd0;
            if (zero_op) begin
              p_q   <= 16'h0;
              state <= S_DONE;
            end else begin
              state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          acc  <= acc_next;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            p_q   <= acc_next;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
            if (!HOLD_RESULT) p_q <= 16'h0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_MUL);
  assign p         = p_q;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb_mul8_seq_ctrl: directed vectors for mul8_seq_ctrl.
// Expected products and latencies are hand-computed constants.

module tb_mul8_seq_ctrl;

  localparam bit HOLD = 1'b1;

`ifdef MUL8_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 4;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  int total;
  int bad;
  int n;
  int nb;
  int errs;

  mul8_seq_ctrl #(.HOLD_RESULT(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call right after the accept edge; counts edges until out_valid.
  task automatic wait_out(input string tag,
                          input int lat,
                          input int prod);
    n  = 0;
    nb = busy ? 1 : 0;
    do begin
      tick();
      n++;
      if (busy && !out_valid) nb++;
    end while (!out_valid && n < 20);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busy"}, nb, (lat == 1) ? 0 : 4);
    chk({tag, "_p"}, p, prod);
  endtask

  task automatic accept(input logic [7:0] ai,
                        input logic [7:0] bi);
    a        = ai;
    b        = bi;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = 8'hxx;
    b        = 8'hxx;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'h0;
    b         = 8'h0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_p", p, 16'h0000);

    // Basic multiply
    out_ready = 1'b1;
    accept(8'hA5, 8'h3C);
    chk("basic_busy0", busy, 1);
    chk("basic_in_ready0", in_ready, 0);
    wait_out("basic", 4, 16'h26AC);
    tick();
    chk("basic_ovalid_off", out_valid, 0);
    chk("basic_in_ready", in_ready, 1);
    chk("basic_p_after", p, HOLD ? 16'h26AC : 16'h0);

    // Max operands with backpressure
    out_ready = 1'b0;
    accept(8'hFF, 8'hFF);
    wait_out("max", 4, 16'hFE01);
    a        = 8'h01;
    b        = 8'h01;
    in_valid = 1'b1;
    errs     = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (p !== 16'hFE01 || !out_valid || in_ready)
        errs++;
    end
    chk("max_stall_stable", errs, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("max_ovalid_off", out_valid, 0);
    chk("max_no_accept_busy", busy, 0);
    chk("max_idle", in_ready, 1);
    chk("max_p_after", p, HOLD ? 16'hFE01 : 16'h0);

    // Back-to-back
    a        = 8'h12;
    b        = 8'h34;
    in_valid = 1'b1;
    tick();
    a = 8'h0F;
    b = 8'hF0;
    wait_out("b2b1", 4, 16'h03A8);
    tick();
    chk("b2b_idle_gap", in_ready, 1);
    tick();
    chk("b2b_second_accept", busy, 1);
    in_valid = 1'b0;
    wait_out("b2b2", 4, 16'h0E10);
    tick();

    // Reset mid-operation
    accept(8'h80, 8'h80);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_in_ready", in_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_p", p, 16'h0000);
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) errs++;
      tick();
    end
    chk("mid_no_result", errs, 0);
    accept(8'h03, 8'h05);
    wait_out("post_rst", 4, 16'h000F);
    tick();

    // Zero operand
    accept(8'h00, 8'h7F);
    wait_out("zero", ZLAT, 16'h0000);
    tick();
    chk("zero_ovalid_off", out_valid, 0);
    chk("zero_p_after", p, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
